neander_mem_port: RTL and testbench

- Memory-access stage directly downstream of the Neander control FSM.
- Owns the REM (address) and RDM (data) registers.
- Turns the controller's one-cycle strobes (regRem_ctrl, regRdm_ctrl, memWrite_ctrl) into a req/ack handshake to an external 256x8 memory with variable wait states.
- Returns read data to RI, ULA and PC, and raises busy for the stall-aware controller revision.

---
 rtl/neander_mem_pkg.sv | 16 +
 rtl/neander_mem_port_if.sv | 25 ++
 rtl/neander_wait_timer.sv | 30 +++
 rtl/neander_mem_port.sv | 140 ++++++++++++++
 tb/tb_neander_mem_port.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/neander_mem_pkg.sv
// neander_mem_pkg: shared types and constants for the Neander memory port.
// Holds the FSM state encoding, the RDM load code and default bus widths.
package neander_mem_pkg;

  localparam int ADDR_W_D = 8;
  localparam int DATA_W_D = 8;

  localparam logic [1:0] RDM_LOAD_AC = 2'b01;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } mem_state_e;

endpackage

// File: rtl/neander_mem_port_if.sv
// neander_mem_port_if: req/ack bus between the memory port and a 256x8 RAM.
// master: req, we, addr, wdata out; ack, rdata in. slave: the reverse.
interface neander_mem_port_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/neander_wait_timer.sv
// neander_wait_timer: wait-state counter, cleared at issue, counts wait cycles.
// Ports: clk, reset (async, low), clear, enable in; expired out (last cycle).
module neander_wait_timer #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && cnt_q != W'(TIMEOUT_CYC)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // High during the TIMEOUT_CYC-th wait cycle; the FSM aborts at its end.
  assign expired = enable && (cnt_q == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/neander_mem_port.sv
// neander_mem_port: REM/RDM owner turning controller strobes into req/ack.
// Ports: clk, reset, strobes/pc_in/ac_in in; rd_data, busy, err out; mem bus.
// Optional NEANDER_MEM_TIMEOUT_EN: abort after TIMEOUT_CYC waits, sticky err.
module neander_mem_port
  import neander_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D
`ifdef NEANDER_MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 15
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regRem_ctrl,
  input  logic              mux_sel,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [1:0]        regRdm_ctrl,
  input  logic [DATA_W-1:0] ac_in,
  input  logic              memWrite_ctrl,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              err,
  neander_mem_port_if.master mem
);

  mem_state_e state_q, state_d;

  logic [ADDR_W-1:0] rem_q;
  logic [ADDR_W-1:0] iss_addr_q;
  logic [DATA_W-1:0] rdm_q;
  logic [DATA_W-1:0] iss_wdata_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              pend_rd_q;
  logic              pend_wr_q;
  logic              issue_rd;
  logic              issue_wr;
  logic              done;
  logic              tmo;
  logic              expired;

`ifdef NEANDER_MEM_TIMEOUT_EN
  logic err_q;

  neander_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (issue_rd | issue_wr),
    .enable (state_q != IDLE),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (tmo) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign expired = 1'b0;
  assign err     = 1'b0;
`endif

  // Writes win over reads; an ack in the timeout cycle still completes.
  always_comb begin
    state_d  = state_q;
    issue_rd = 1'b0;
    issue_wr = 1'b0;
    done     = 1'b0;
    tmo      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_wr_q) begin
          issue_wr = 1'b1;
          state_d  = WR_WAIT;
        end else if (pend_rd_q) begin
          issue_rd = 1'b1;
          state_d  = RD_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (mem.ack) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (expired) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      rdm_q       <= '0;
      iss_addr_q  <= '0;
      iss_wdata_q <= '0;
      rd_data_q   <= '0;
      pend_rd_q   <= 1'b0;
      pend_wr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (regRem_ctrl) begin
        rem_q <= mux_sel ? ADDR_W'(rd_data_q) : pc_in;
      end
      if (regRdm_ctrl == RDM_LOAD_AC) begin
        rdm_q <= ac_in;
      end
      // A new strobe in the issue cycle keeps its bit set as a fresh op.
      pend_rd_q <= regRem_ctrl | (pend_rd_q & ~issue_rd);
      pend_wr_q <= memWrite_ctrl | (pend_wr_q & ~issue_wr);
      if (issue_rd | issue_wr) begin
        iss_addr_q  <= rem_q;
        iss_wdata_q <= rdm_q;
      end
      if (state_q == RD_WAIT && done) begin
        rd_data_q <= mem.rdata;
      end else if (state_q == RD_WAIT && tmo) begin
        rd_data_q <= '0;
      end
    end
  end

  assign mem.req   = (state_q != IDLE);
  assign mem.we    = (state_q == WR_WAIT);
  assign mem.addr  = iss_addr_q;
  assign mem.wdata = iss_wdata_q;
  assign rd_data   = rd_data_q;
  assign busy      = (state_q != IDLE) | pend_rd_q | pend_wr_q;

endmodule

// File: tb/tb_neander_mem_port.sv
// tb_neander_mem_port: scoreboard bench with a RAM responder and a model.
// Expected bus transactions and read data are queued by the stimulus side.
module tb_neander_mem_port;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       regRem_ctrl = 1'b0;
  logic       mux_sel = 1'b0;
  logic [7:0] pc_in = 8'h00;
  logic [1:0] regRdm_ctrl = 2'b00;
  logic [7:0] ac_in = 8'h00;
  logic       memWrite_ctrl = 1'b0;
  logic [7:0] rd_data;
  logic       busy;
  logic       err;

  neander_mem_port_if #(.ADDR_W(8), .DATA_W(8)) mif ();

  neander_mem_port dut (
    .clk          (clk),
    .reset        (reset),
    .regRem_ctrl  (regRem_ctrl),
    .mux_sel      (mux_sel),
    .pc_in        (pc_in),
    .regRdm_ctrl  (regRdm_ctrl),
    .ac_in        (ac_in),
    .memWrite_ctrl(memWrite_ctrl),
    .rd_data      (rd_data),
    .busy         (busy),
    .err          (err),
    .mem          (mif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } txn_t;

  int   checks = 0;
  int   errors = 0;
  txn_t exp_txn[$];
  logic [7:0] exp_rd[$];

  logic [7:0] ref_mem[256];
  logic [7:0] r_rem = 8'h00;
  logic [7:0] r_rdm = 8'h00;
  logic [7:0] r_last = 8'h00;
  int   wait_cfg = -1;
  int   stray_req = 0;

  function automatic logic [7:0] init_val(int i);
    return 8'((i * 73) ^ 8'h5C);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RAM responder: ack after a configurable number of wait cycles.
  logic [7:0] mem[256];
  initial begin : responder
    int  wcnt;
    bit  in_txn;
    int  stray_done;
    wcnt = 0;
    in_txn = 0;
    stray_done = 0;
    mif.ack = 1'b0;
    mif.rdata = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      #1;
      mif.rdata = 8'($urandom);
      if (!reset) begin
        mif.ack = 1'b0;
        in_txn = 0;
      end else if (mif.ack) begin
        mif.ack = 1'b0;
        in_txn = 0;
      end else if (mif.req) begin
        if (!in_txn) begin
          in_txn = 1;
          wcnt = (wait_cfg < 0) ? $urandom_range(0, 4) : wait_cfg;
        end
        if (wcnt == 0) begin
          mif.ack = 1'b1;
          if (mif.we) mem[mif.addr] = mif.wdata;
          else mif.rdata = mem[mif.addr];
        end else begin
          wcnt--;
        end
      end else begin
        in_txn = 0;
        if (stray_req != stray_done) begin
          stray_done = stray_req;
          mif.ack = 1'b1;
          mif.rdata = 8'hFF;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a request or data.
  initial begin : monitor
    bit   prev_req;
    bit   rd_flag;
    txn_t cur;
    prev_req = 0;
    rd_flag = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_req = 0;
        rd_flag = 0;
      end else begin
        if (rd_flag) begin
          rd_flag = 0;
          if (exp_rd.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected: got %0h expected none", rd_data);
          end else begin
            chk("rd_data", rd_data, exp_rd.pop_front());
          end
        end
        if (mif.req) begin
          chk("busy_during_req", busy, 1);
          if (!prev_req) begin
            if (exp_txn.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL txn_unexpected: got we=%0b addr=%0h expected none",
                       mif.we, mif.addr);
              cur = {mif.we, mif.addr, mif.wdata};
            end else begin
              cur = exp_txn.pop_front();
            end
          end
          chk("mem_we", mif.we, cur.we);
          chk("mem_addr", mif.addr, cur.addr);
          if (cur.we) chk("mem_wdata", mif.wdata, cur.wdata);
          if (mif.ack && !mif.we) rd_flag = 1;
        end
        prev_req = mif.req;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One controller cycle of strobes, plus the model's view of its effect.
  task automatic op(bit rem_ld, bit msel, logic [7:0] pc,
                    logic [1:0] rdm_c, logic [7:0] ac, bit wr);
    if (rdm_c == 2'b01) r_rdm = ac;
    if (rem_ld) r_rem = msel ? r_last : pc;
    if (wr) begin
      exp_txn.push_back({1'b1, r_rem, r_rdm});
      ref_mem[r_rem] = r_rdm;
    end
    if (rem_ld) begin
      exp_txn.push_back({1'b0, r_rem, 8'h00});
      r_last = ref_mem[r_rem];
      exp_rd.push_back(r_last);
    end
    regRem_ctrl = rem_ld;
    mux_sel = msel;
    pc_in = pc;
    regRdm_ctrl = rdm_c;
    ac_in = ac;
    memWrite_ctrl = wr;
    tick();
    regRem_ctrl = 1'b0;
    regRdm_ctrl = 2'b00;
    memWrite_ctrl = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy=1 expected busy=0", name);
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin : stim
    int reqc;
    logic [4:0] seq;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

    repeat (3) tick();
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_req", mif.req, 0);
    chk("rst_we", mif.we, 0);
    reset = 1'b1;
    repeat (2) tick();

    // Put A7 at 05 via write, then time a zero-wait read.
    wait_cfg = 0;
    op(1, 0, 8'h05, 2'b01, 8'hA7, 1);
    wait_idle("prep05");
    op(1, 0, 8'h05, 2'b00, 8'h00, 0);
    chk("lat_req_pre", mif.req, 0);
    chk("lat_busy_pre", busy, 1);
    tick();
    chk("lat_req", mif.req, 1);
    chk("lat_addr", mif.addr, 8'h05);
    tick();
    chk("lat_rd_data", rd_data, 8'hA7);
    chk("lat_busy_post", busy, 0);
    tick();

    // Write with three wait states.
    op(1, 0, 8'h80, 2'b00, 8'h00, 0);
    wait_idle("rd80");
    wait_cfg = 3;
    op(0, 0, 8'h00, 2'b01, 8'h3C, 1);
    reqc = 0;
    repeat (8) begin
      if (mif.req) reqc++;
      tick();
    end
    chk("wr_hold_cycles", reqc, 4);
    wait_idle("wr80");

    // Indirect address through rd_data.
    wait_cfg = -1;
    op(1, 0, 8'h10, 2'b01, 8'h42, 1);
    wait_idle("prep10");
    chk("ind_rd_data", rd_data, 8'h42);
    op(1, 1, 8'h99, 2'b00, 8'h00, 0);
    wait_idle("ind");

    // Read and write strobed together: write, idle cycle, read.
    wait_cfg = 0;
    op(1, 0, 8'h21, 2'b01, 8'h5A, 1);
    seq = '0;
    for (int i = 0; i < 5; i++) begin
      seq = {seq[3:0], mif.req};
      tick();
    end
    chk("both_req_seq", seq, 5'b01010);
    wait_idle("both");
    chk("both_rd_data", rd_data, 8'h5A);

    // Stray ack while idle must not touch rd_data.
    stray_req++;
    repeat (3) tick();
    chk("stray_rd_data", rd_data, r_last);
    chk("stray_busy", busy, 0);

    // Two reads strobed while busy merge into one using the latest REM.
    wait_cfg = 6;
    op(1, 0, 8'h30, 2'b00, 8'h00, 0);
    regRem_ctrl = 1'b1;
    mux_sel = 1'b0;
    pc_in = 8'h31;
    tick();
    pc_in = 8'h32;
    tick();
    regRem_ctrl = 1'b0;
    r_rem = 8'h32;
    exp_txn.push_back({1'b0, r_rem, 8'h00});
    r_last = ref_mem[r_rem];
    exp_rd.push_back(r_last);
    wait_idle("merge");
    chk("merge_rd_data", rd_data, ref_mem[8'h32]);

`ifdef NEANDER_MEM_TIMEOUT_EN
    wait_cfg = 14;
    op(1, 0, 8'h50, 2'b00, 8'h00, 0);
    wait_idle("ack15");
    chk("ack15_err", err, 0);
    wait_cfg = 100;
    op(1, 0, 8'h51, 2'b00, 8'h00, 0);
    void'(exp_rd.pop_back());
    r_last = 8'h00;
    reqc = 0;
    repeat (20) begin
      if (mif.req) reqc++;
      tick();
    end
    chk("tmo_req_cycles", reqc, 15);
    chk("tmo_err", err, 1);
    chk("tmo_rd_data", rd_data, 8'h00);
    wait_cfg = 0;
    op(1, 0, 8'h52, 2'b00, 8'h00, 0);
    wait_idle("after_tmo");
    chk("tmo_err_sticky", err, 1);
`endif

    // Reset in the middle of a read.
    wait_cfg = 10;
    op(1, 0, 8'h44, 2'b00, 8'h00, 0);
    void'(exp_rd.pop_back());
    reqc = 0;
    while (!mif.req && reqc < 5) begin
      tick();
      reqc++;
    end
    chk("rst_mid_req_seen", mif.req, 1);
    reset = 1'b0;
    #1;
    chk("rst_mid_req", mif.req, 0);
    chk("rst_mid_rd_data", rd_data, 8'h00);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_err", err, 0);
    r_rem = 8'h00;
    r_rdm = 8'h00;
    r_last = 8'h00;
    tick();
    tick();
    reset = 1'b1;
    reqc = 0;
    repeat (6) begin
      if (mif.req) reqc++;
      tick();
    end
    chk("rst_no_txn", reqc, 0);

    // Randomised sequential operations.
    wait_cfg = -1;
    for (int k = 0; k < 60; k++) begin
      int t;
      t = $urandom_range(0, 3);
      case (t)
        0: op(1, 1'($urandom), 8'($urandom), 2'b00, 8'h00, 0);
        1: op(0, 0, 8'h00, 2'($urandom), 8'($urandom), 1);
        2: op(1, 1'($urandom), 8'($urandom), 2'($urandom), 8'($urandom), 1);
        default: op(0, 0, 8'h00, 2'($urandom), 8'($urandom), 0);
      endcase
      wait_idle("rand");
    end

    repeat (3) tick();
    chk("txn_queue_empty", exp_txn.size(), 0);
    chk("rd_queue_empty", exp_rd.size(), 0);
`ifndef NEANDER_MEM_TIMEOUT_EN
    chk("err_tied_low", err, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
